// File: rtl/mp_bus_pkg.sv
// mp_bus_pkg: address map, FSM states and CTRL_START layout shared by the bus master
package mp_bus_pkg;
  localparam logic [15:0] ADDR_DATA_BASE  = 16'h0000;
  localparam logic [15:0] ADDR_INST_BASE  = 16'h0010;
  localparam logic [15:0] ADDR_CTRL_START = 16'h0020;
  localparam logic [15:0] ADDR_CTRL_CLEAR = 16'h0021;
  localparam logic [15:0] ADDR_RESULT     = 16'h0030;
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_WAIT, ST_RD_REQ, ST_RD_CAP, ST_CLEAR, ST_RESP
  } state_t;
  typedef struct packed {
    logic [23:0] rsvd_hi;
    logic [3:0]  n_inst;
    logic [2:0]  rsvd_lo;
    logic        start;
  } ctrl_start_t;
  function automatic logic [31:0] ctrl_start_word(input logic [3:0] n);
    ctrl_start_t c;
    c = '0;
    c.n_inst = n;
    c.start = 1'b1;
    return c;
  endfunction
endpackage

// File: rtl/mp_bus_wdog.sv
// mp_bus_wdog: cycle counter that flags expiry on the TIMEOUT-th enabled cycle
module mp_bus_wdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
  assign expire = en && cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/mp_bus_master.sv
// mp_bus_master: loads, runs, reads and clears the mini-processor slave; MP_BUS_MASTER_WDOG_EN adds a WAIT watchdog
module mp_bus_master
  import mp_bus_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int DEPTH   = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        H_valid,
  output logic        H_ready,
  input  logic        H_is_inst,
  input  logic [31:0] H_data,
  input  logic        H_go,
  output logic        R_valid,
  input  logic        R_ready,
  output logic [63:0] R_data,
  output logic        R_err,
  output logic        s0_sel,
  output logic        S_wr,
  output logic [15:0] S_addr,
  output logic [31:0] S_din,
  input  logic [63:0] s_dout,
  input  logic        Interrupt_out
);
  localparam int CW = $clog2(DEPTH + 1);
  state_t state, state_n;
  logic [CW-1:0] d_cnt, i_cnt, sel_cnt;
  logic go_pend, acc, wd_exp, sel_n, wr_n;
  logic [15:0] addr_n;
  logic [31:0] din_n;
  assign sel_cnt = H_is_inst ? i_cnt : d_cnt;
  assign H_ready = state == ST_IDLE && sel_cnt < CW'(DEPTH);
  assign acc = H_valid & H_ready;
  assign R_valid = state == ST_RESP;
`ifdef MP_BUS_MASTER_WDOG_EN
  mp_bus_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk(Clk), .rst(Reset), .clr(state != ST_WAIT), .en(state == ST_WAIT), .expire(wd_exp)
  );
  always_ff @(posedge Clk)
    if (Reset) R_err <= 1'b0;
    else if (state == ST_WAIT && state_n == ST_RD_REQ) R_err <= !Interrupt_out;
`else
  assign wd_exp = 1'b0;
  assign R_err = 1'b0;
`endif
  // bus registers are loaded with the cycle belonging to the state being entered
  always_comb begin
    state_n = state;
    sel_n = 1'b0;
    wr_n = 1'b0;
    addr_n = '0;
    din_n = '0;
    case (state)
      ST_IDLE:
        if (acc) begin
          sel_n = 1'b1;
          wr_n = 1'b1;
          addr_n = (H_is_inst ? ADDR_INST_BASE : ADDR_DATA_BASE) + 16'(sel_cnt);
          din_n = H_data;
        end else if (go_pend || H_go) state_n = ST_START;
      ST_START:  state_n = ST_WAIT;
      ST_WAIT:   state_n = (Interrupt_out || wd_exp) ? ST_RD_REQ : ST_WAIT;
      ST_RD_REQ: state_n = ST_RD_CAP;
      ST_RD_CAP: state_n = ST_CLEAR;
      ST_CLEAR:  state_n = ST_RESP;
      ST_RESP:   state_n = R_ready ? ST_IDLE : ST_RESP;
      default:   state_n = ST_IDLE;
    endcase
    if (state_n != state) begin
      sel_n = state_n inside {ST_START, ST_RD_REQ, ST_CLEAR};
      wr_n = state_n inside {ST_START, ST_CLEAR};
      addr_n = state_n == ST_START ? ADDR_CTRL_START :
               state_n == ST_RD_REQ ? ADDR_RESULT :
               state_n == ST_CLEAR ? ADDR_CTRL_CLEAR : 16'h0000;
      din_n = state_n == ST_START ? ctrl_start_word(4'(i_cnt)) :
              state_n == ST_CLEAR ? 32'h1 : 32'h0;
    end
  end
  always_ff @(posedge Clk)
    if (Reset) begin
      state <= ST_IDLE;
      d_cnt <= '0;
      i_cnt <= '0;
      go_pend <= 1'b0;
      s0_sel <= 1'b0;
      S_wr <= 1'b0;
      S_addr <= '0;
      S_din <= '0;
      R_data <= '0;
    end else begin
      state <= state_n;
      s0_sel <= sel_n;
      S_wr <= wr_n;
      S_addr <= addr_n;
      S_din <= din_n;
      if (acc && H_is_inst) i_cnt <= i_cnt + CW'(1);
      if (acc && !H_is_inst) d_cnt <= d_cnt + CW'(1);
      if (state == ST_IDLE && H_go) go_pend <= 1'b1;
      if (state == ST_RD_CAP) R_data <= s_dout;
      if (state == ST_RESP && R_ready) begin
        d_cnt <= '0;
        i_cnt <= '0;
        go_pend <= 1'b0;
      end
    end
endmodule

// File: tb/tb_mp_bus_master.sv
// tb_mp_bus_master: randomized scoreboard bench with a cycle-level reference of bus and result traffic
module tb_mp_bus_master;
  localparam int DEPTH = 10;
  localparam int TMO = 16;
  logic Clk = 0, Reset = 1, H_valid = 0, H_is_inst = 0, H_go = 0, R_ready = 0, Interrupt_out = 0;
  logic [31:0] H_data = '0;
  logic [63:0] s_dout = '0;
  logic H_ready, R_valid, R_err, s0_sel, S_wr;
  logic [63:0] R_data;
  logic [15:0] S_addr;
  logic [31:0] S_din;

  mp_bus_master #(.TIMEOUT(TMO), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .H_valid(H_valid), .H_ready(H_ready), .H_is_inst(H_is_inst),
    .H_data(H_data), .H_go(H_go), .R_valid(R_valid), .R_ready(R_ready), .R_data(R_data),
    .R_err(R_err), .s0_sel(s0_sel), .S_wr(S_wr), .S_addr(S_addr), .S_din(S_din),
    .s_dout(s_dout), .Interrupt_out(Interrupt_out)
  );

  always #5 Clk = ~Clk;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct { logic wr; logic [15:0] addr; logic [31:0] din; int at; } bus_t;
  typedef struct { logic [63:0] data; logic err; int at; } res_t;
  bus_t bus_q[$];
  res_t res_q[$];
  int checks = 0, errors = 0;
  int dcnt = 0, icnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // monitor: every bus cycle and every result is popped against the expectations
  initial begin
    logic rv_prev, hs_prev;
    logic [63:0] rd_prev;
    bus_t b;
    res_t r;
    rv_prev = 0; hs_prev = 0; rd_prev = '0;
    forever begin
      @(negedge Clk);
      if (s0_sel) begin
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_unexpected: got wr=%0b addr=%h din=%h at cycle %0d expected no bus cycle", S_wr, S_addr, S_din, cyc);
        end else begin
          b = bus_q.pop_front();
          chk("bus_wr", S_wr, b.wr);
          chk("bus_addr", S_addr, b.addr);
          chk("bus_din", S_din, b.din);
          chk("bus_cycle", cyc, b.at);
        end
      end
      if (!S_wr) chk("din_zero_when_read", S_din, 0);
      if (R_valid && !rv_prev) begin
        if (res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_valid_unexpected: got R_valid=1 at cycle %0d expected 0", cyc);
        end else chk("r_valid_cycle", cyc, res_q[0].at);
      end
      if (R_valid && rv_prev && !hs_prev) chk("r_data_stable", R_data, rd_prev);
      if (R_valid && R_ready && res_q.size() != 0) begin
        r = res_q.pop_front();
        chk("r_data", R_data, r.data);
        chk("r_err", R_err, r.err);
      end
      rv_prev = R_valid;
      hs_prev = R_valid && R_ready;
      rd_prev = R_data;
    end
  end

  task automatic send(input bit inst, input logic [31:0] d, input bit go);
    bit rdy;
    H_valid = 1; H_is_inst = inst; H_data = d; H_go = go;
    @(negedge Clk);
    rdy = (inst ? icnt : dcnt) < DEPTH;
    chk("h_ready", H_ready, rdy);
    if (rdy) begin
      bus_q.push_back('{1'b1, (inst ? 16'h0010 : 16'h0000) + 16'(inst ? icnt : dcnt), d, cyc + 1});
      if (inst) icnt++; else dcnt++;
    end
    tick();
    H_valid = 0; H_go = 0;
  endtask

  task automatic noise_cycle();
    H_go = 1'($urandom); H_valid = 1'($urandom); H_is_inst = 1'($urandom); H_data = $urandom;
    @(negedge Clk);
    chk("h_ready_busy", H_ready, 0);
    tick();
    H_go = 0; H_valid = 0;
  endtask

  task automatic go_run(input bit with_word, input bit winst, input logic [31:0] wd, input int dly,
                        input logic [63:0] res, input int bp, input bit tmo);
    int s, t;
    if (with_word) begin
      send(winst, wd, 1);
      s = cyc + 1;
      tick();
    end else begin
      H_go = 1;
      s = cyc + 1;
      tick();
      H_go = 0;
    end
    bus_q.push_back('{1'b1, 16'h0020, 32'(icnt * 16 + 1), s});
    t = tmo ? s + TMO : s + dly;
    bus_q.push_back('{1'b0, 16'h0030, 32'h0, t + 1});
    bus_q.push_back('{1'b1, 16'h0021, 32'h1, t + 3});
    res_q.push_back('{res, tmo, t + 4});
    while (cyc < t) noise_cycle();
    Interrupt_out = !tmo;
    while (cyc < t + 4) begin
      s_dout = (cyc == t + 2) ? res : {$urandom, $urandom};
      noise_cycle();
    end
    Interrupt_out = 0;
    s_dout = {$urandom, $urandom};
    repeat (bp) noise_cycle();
    R_ready = 1;
    tick();
    R_ready = 0;
    dcnt = 0; icnt = 0;
  endtask

  initial begin
    int nd, ni, tot, rd, ri;
    bit gw, inst;
    logic [31:0] d;
    repeat (3) tick();
    @(negedge Clk);
    chk("rst_s0_sel", s0_sel, 0);
    chk("rst_s_wr", S_wr, 0);
    chk("rst_s_addr", S_addr, 0);
    chk("rst_s_din", S_din, 0);
    chk("rst_r_valid", R_valid, 0);
    chk("rst_r_data", R_data, 0);
    chk("rst_r_err", R_err, 0);
    tick();
    Reset = 0;
    // directed load and go
    send(0, 32'hA, 0); send(1, $urandom, 0); send(0, 32'hB, 0); send(1, $urandom, 0); send(0, 32'hC, 0);
    go_run(0, 0, 0, 5, 64'h1234_5678_9ABC_DEF0, 0, 0);
    // data region overflow, instruction region still open, long back-pressure
    for (int k = 0; k < 11; k++) send(0, $urandom, 0);
    send(1, $urandom, 0);
    go_run(0, 0, 0, 3, {$urandom, $urandom}, 20, 0);
    // randomized runs
    repeat (6) begin
      nd = $urandom_range(0, DEPTH); ni = $urandom_range(0, DEPTH);
      tot = nd + ni; rd = nd; ri = ni;
      gw = tot > 0 && 1'($urandom);
      for (int k = 0; k < tot; k++) begin
        inst = rd == 0 ? 1'b1 : ri == 0 ? 1'b0 : 1'($urandom);
        if (inst) ri--; else rd--;
        d = $urandom;
        if (gw && k == tot - 1) go_run(1, inst, d, $urandom_range(1, 10), {$urandom, $urandom}, $urandom_range(0, 5), 0);
        else send(inst, d, 0);
      end
      if (!gw) go_run(0, 0, 0, $urandom_range(1, 10), {$urandom, $urandom}, $urandom_range(0, 5), 0);
    end
`ifdef MP_BUS_MASTER_WDOG_EN
    send(0, $urandom, 0); send(1, $urandom, 0);
    go_run(0, 0, 0, 0, {$urandom, $urandom}, 2, 1);
`endif
    // reset while waiting for the interrupt
    send(0, $urandom, 0); send(1, $urandom, 0);
    H_go = 1;
    bus_q.push_back('{1'b1, 16'h0020, 32'(icnt * 16 + 1), cyc + 1});
    tick();
    H_go = 0;
    repeat (3) tick();
    Reset = 1;
    tick();
    Reset = 0;
    dcnt = 0; icnt = 0;
    @(negedge Clk);
    chk("wait_rst_s0_sel", s0_sel, 0);
    chk("wait_rst_s_wr", S_wr, 0);
    chk("wait_rst_s_addr", S_addr, 0);
    chk("wait_rst_s_din", S_din, 0);
    chk("wait_rst_r_valid", R_valid, 0);
    chk("wait_rst_r_data", R_data, 0);
    chk("wait_rst_r_err", R_err, 0);
    chk("wait_rst_h_ready_idle", H_ready, 1);
    tick();
    send(0, $urandom, 0); send(1, $urandom, 0);
    go_run(0, 0, 0, 2, {$urandom, $urandom}, 1, 0);
    repeat (3) tick();
    chk("bus_q_drained", bus_q.size(), 0);
    chk("res_q_drained", res_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
